// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM state encoding and the byte-lane alignment helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // Number of address LSBs that select a byte within one data word.
  function automatic int unsigned addr_lsb(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB master: converts single read/write commands into APB SETUP/ACCESS transfers,
// rejecting misaligned addresses and bounding the ACCESS phase with a timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam int unsigned   ADDR_LSB   = addr_lsb(DW);
  localparam int unsigned   CW         = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] ALIGN_MASK = AW'((1 << ADDR_LSB) - 1);

  apb_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          aligned;

  // Reset gates cmd_ready so nothing is accepted while PRESET is high.
  assign cmd_ready = (state == IDLE) && !PRESET;
  assign aligned   = (cmd_addr & ALIGN_MASK) == '0;
  assign wait_nxt  = wait_cnt + CW'(1);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (aligned) begin
              PADDR  <= cmd_addr;
              PWDATA <= cmd_wdata;
              PWRITE <= cmd_write;
              PSEL   <= 1'b1;
              state  <= SETUP;
            end else begin
              // Misaligned: answer directly without touching the bus.
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
              state       <= RESP;
            end
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            state       <= RESP;
          end else if (wait_nxt == CW'(TIMEOUT)) begin
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            wait_cnt    <= wait_nxt;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: 16-word RAM slave with programmable wait states, directed
// scenarios and randomized transactions checked against a transaction-level model.
module tb_apb_master;
  import apb_pkg::*;

  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned BYTES   = 1 << addr_lsb(DW);
  localparam int unsigned WORDS   = 16;
  localparam int unsigned HANG    = 1000;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  apb_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // RAM slave: ready after slave_wait ACCESS cycles, PSLVERR beyond the last word.
  logic [DW-1:0] ram [WORDS] = '{default: '0};
  int unsigned   slave_wait  = 0;
  int unsigned   acc_cnt     = 0;
  logic          in_range;

  always_comb begin
    in_range = PADDR < AW'(WORDS * BYTES);
    PREADY   = PSEL && PENABLE && (acc_cnt >= slave_wait);
    PSLVERR  = PREADY && !in_range;
    PRDATA   = in_range ? ram[PADDR[5:2]] : 32'hBAD0_BAD0;
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (PREADY && PWRITE && in_range) ram[PADDR[5:2]] <= PWDATA;
  end

  typedef struct {
    logic          err;
    logic          to;
    logic [DW-1:0] rdata;
    int            lat;
    int            acc;
    bit            psel;
  } exp_t;

  typedef struct {
    bit            hs_ok;
    int            lat;
    int            acc;
    bit            psel_seen;
    bit            psel_end;
    bit            setup_ok;
    bit            stable;
    logic          err;
    logic          to;
    logic [DW-1:0] rdata;
    bit            hold_ok;
    bit            release_ok;
  } obs_t;

  logic [DW-1:0] model_mem [WORDS] = '{default: '0};

  // Transaction-level reference: outcome and timing from the block's rules.
  task automatic model_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int unsigned waits, output exp_t e);
    int unsigned idx;
    idx     = int'(addr) / BYTES;
    e.err   = 1'b0;
    e.to    = 1'b0;
    e.rdata = '0;
    e.psel  = 1'b1;
    if (int'(addr) % BYTES != 0) begin
      e.err = 1'b1; e.lat = 1; e.acc = 0; e.psel = 1'b0;
    end else if (waits >= TIMEOUT) begin
      e.err = 1'b1; e.to = 1'b1; e.lat = 2 + TIMEOUT; e.acc = TIMEOUT;
    end else begin
      e.lat = 3 + int'(waits);
      e.acc = int'(waits) + 1;
      if (idx >= WORDS) e.err = 1'b1;
      else if (wr) model_mem[idx] = wd;
      else e.rdata = model_mem[idx];
    end
  endtask

  // Drives one command, observes the bus and response, then consumes the response.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int hold, output obs_t o);
    int n;
    o = '{default: 0};
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge PCLK); n++; end
    o.hs_ok = cmd_ready;
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    o.lat = 1;
    o.setup_ok = PSEL && !PENABLE && PADDR === addr && PWRITE === wr && PWDATA === wd;
    o.stable = 1'b1;
    while (!rsp_valid && o.lat < 300) begin
      if (PSEL) o.psel_seen = 1'b1;
      if (PSEL && PENABLE) begin
        o.acc++;
        if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd) o.stable = 1'b0;
      end
      @(posedge PCLK); #1;
      o.lat++;
    end
    o.psel_seen = o.psel_seen || PSEL;
    o.psel_end  = PSEL || PENABLE;
    o.err = rsp_err; o.to = rsp_timeout; o.rdata = rsp_rdata;
    o.hold_ok = rsp_valid;
    for (int i = 0; i < hold; i++) begin
      @(posedge PCLK); #1;
      if (!rsp_valid || rsp_err !== o.err || rsp_timeout !== o.to || rsp_rdata !== o.rdata || cmd_ready)
        o.hold_ok = 1'b0;
    end
    @(negedge PCLK); rsp_ready = 1'b1;
    @(posedge PCLK); #1; rsp_ready = 1'b0;
    o.release_ok = !rsp_valid && cmd_ready;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0) begin
      errors++; $display("FAIL reset_apb: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h want all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    checks++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_rsp: valid=%b err=%b to=%b rdata=%h want all 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    @(negedge PCLK); PRESET = 1'b0; #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_first_ready: got %b want 1", cmd_ready); end
    @(posedge PCLK); #1;
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0) begin
      errors++; $display("FAIL reset_first_accept: psel=%b pen=%b want 1 0", PSEL, PENABLE);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(posedge PCLK);
    @(negedge PCLK); rsp_ready = 1'b0;
  endtask

  task automatic test_write_read();
    obs_t o; exp_t e;
    slave_wait = 0;
    model_txn(1'b1, 16'h0004, 32'hDEADBEEF, 0, e);
    run_txn(1'b1, 16'h0004, 32'hDEADBEEF, 0, o);
    checks++; if (o.err !== 1'b0 || o.rdata !== '0) begin errors++; $display("FAIL wr_rsp: err=%b rdata=%h want 0 0", o.err, o.rdata); end
    checks++; if (o.lat !== 3 || !o.setup_ok) begin errors++; $display("FAIL wr_latency: lat=%0d setup_ok=%b want 3 1", o.lat, o.setup_ok); end
    slave_wait = 2;
    model_txn(1'b0, 16'h0004, 32'h0, 2, e);
    run_txn(1'b0, 16'h0004, 32'h0, 1, o);
    checks++; if (o.rdata !== 32'hDEADBEEF || o.err !== 1'b0) begin
      errors++; $display("FAIL rd_data: rdata=%h err=%b want deadbeef 0", o.rdata, o.err);
    end
    checks++; if (o.lat !== 5 || o.acc !== 3) begin errors++; $display("FAIL rd_wait_latency: lat=%0d acc=%0d want 5 3", o.lat, o.acc); end
  endtask

  task automatic test_range_err();
    obs_t o; exp_t e;
    slave_wait = 0;
    model_txn(1'b0, 16'h0040, 32'h0, 0, e);
    run_txn(1'b0, 16'h0040, 32'h0, 0, o);
    checks++; if (o.err !== 1'b1 || o.to !== 1'b0 || o.rdata !== '0) begin
      errors++; $display("FAIL range_err: err=%b to=%b rdata=%h want 1 0 0", o.err, o.to, o.rdata);
    end
    checks++; if (o.acc !== 1 || !o.psel_seen) begin errors++; $display("FAIL range_bus: acc=%0d psel=%b want 1 1", o.acc, o.psel_seen); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    slave_wait = HANG;
    model_txn(1'b0, 16'h0008, 32'h0, HANG, e);
    run_txn(1'b0, 16'h0008, 32'h0, 2, o);
    checks++; if (o.err !== 1'b1 || o.to !== 1'b1 || o.rdata !== '0) begin
      errors++; $display("FAIL timeout_rsp: err=%b to=%b rdata=%h want 1 1 0", o.err, o.to, o.rdata);
    end
    checks++; if (o.acc !== int'(TIMEOUT) || o.psel_end) begin
      errors++; $display("FAIL timeout_cycles: acc=%0d psel_end=%b want %0d 0", o.acc, o.psel_end, TIMEOUT);
    end
    checks++; if (!o.hold_ok || !o.release_ok) begin errors++; $display("FAIL timeout_hold: hold=%b release=%b want 1 1", o.hold_ok, o.release_ok); end
    slave_wait = 0;
  endtask

  task automatic test_misaligned();
    obs_t o; exp_t e;
    model_txn(1'b1, 16'h0002, 32'h1234_5678, 0, e);
    run_txn(1'b1, 16'h0002, 32'h1234_5678, 0, o);
    checks++; if (o.psel_seen || o.lat !== 1) begin errors++; $display("FAIL misalign_bus: psel=%b lat=%0d want 0 1", o.psel_seen, o.lat); end
    checks++; if (o.err !== 1'b1 || o.to !== 1'b0 || o.rdata !== '0) begin
      errors++; $display("FAIL misalign_rsp: err=%b to=%b rdata=%h want 1 0 0", o.err, o.to, o.rdata);
    end
  endtask

  task automatic test_backpressure();
    exp_t e, e2; int n; logic [DW-1:0] nd;
    nd = $urandom();
    slave_wait = 0;
    model_txn(1'b0, 16'h0004, 32'h0, 0, e);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0004; cmd_wdata = '0; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge PCLK); n++; end
    @(posedge PCLK); #1;
    cmd_write = 1'b1; cmd_addr = 16'h0010; cmd_wdata = nd;
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge PCLK); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b want 1 %h 0 0", i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, e.rdata);
      end
      @(posedge PCLK); #1;
    end
    @(negedge PCLK); rsp_ready = 1'b1;
    @(posedge PCLK); #1; rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
    end
    @(posedge PCLK); #1;
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 16'h0010 || PWRITE !== 1'b1) begin
      errors++; $display("FAIL bp_next_accept: psel=%b pen=%b paddr=%h pwr=%b want 1 0 0010 1", PSEL, PENABLE, PADDR, PWRITE);
    end
    cmd_valid = 1'b0;
    model_txn(1'b1, 16'h0010, nd, 0, e2);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge PCLK); #1; n++; end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== e2.err) begin
      errors++; $display("FAIL bp_next_rsp: valid=%b err=%b want 1 %b", rsp_valid, rsp_err, e2.err);
    end
    @(negedge PCLK); rsp_ready = 1'b1;
    @(posedge PCLK); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    obs_t o; exp_t e; int n; bit quiet;
    slave_wait = HANG;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h000C; cmd_wdata = 32'hA5A5_5A5A; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge PCLK); n++; end
    @(posedge PCLK); #1; cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    checks++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin errors++; $display("FAIL abort_in_access: psel=%b pen=%b want 1 1", PSEL, PENABLE); end
    @(negedge PCLK); PRESET = 1'b1;
    @(posedge PCLK); #1;
    checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL abort_edge: psel=%b pen=%b valid=%b ready=%b want 0 0 0 0", PSEL, PENABLE, rsp_valid, cmd_ready);
    end
    @(negedge PCLK); PRESET = 1'b0; slave_wait = 0;
    quiet = 1'b1;
    repeat (4) begin @(posedge PCLK); #1; if (rsp_valid || PSEL) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL abort_no_rsp: activity after abort, want none"); end
    model_txn(1'b1, 16'h0008, 32'h0BAD_F00D, 0, e);
    run_txn(1'b1, 16'h0008, 32'h0BAD_F00D, 0, o);
    checks++; if (o.err !== 1'b0 || o.lat !== 3) begin errors++; $display("FAIL abort_fresh_wr: err=%b lat=%0d want 0 3", o.err, o.lat); end
    model_txn(1'b0, 16'h0008, 32'h0, 0, e);
    run_txn(1'b0, 16'h0008, 32'h0, 0, o);
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL abort_readback: rdata=%h want %h", o.rdata, e.rdata); end
    checks++; if (ram[3] !== model_mem[3]) begin errors++; $display("FAIL abort_no_write: ram[3]=%h want %h", ram[3], model_mem[3]); end
  endtask

  task automatic test_random();
    obs_t o; exp_t e; logic wr; logic [AW-1:0] a; logic [DW-1:0] d;
    int unsigned w, sel; int hold;
    for (int t = 0; t < 40; t++) begin
      wr   = 1'($urandom_range(0, 1));
      d    = $urandom();
      sel  = $urandom_range(0, 9);
      if (sel <= 6) a = AW'($urandom_range(0, WORDS - 1) * BYTES);
      else if (sel == 7) a = AW'(WORDS * BYTES + $urandom_range(0, 200) * BYTES);
      else a = AW'($urandom_range(0, WORDS - 1) * BYTES + $urandom_range(1, BYTES - 1));
      w    = ($urandom_range(0, 9) == 0) ? HANG : $urandom_range(0, 4);
      hold = int'($urandom_range(0, 3));
      slave_wait = w;
      model_txn(wr, a, d, w, e);
      run_txn(wr, a, d, hold, o);
      checks++; if (!o.hs_ok) begin errors++; $display("FAIL rnd%0d_handshake: cmd_ready never rose", t); end
      checks++; if (o.lat !== e.lat || o.acc !== e.acc) begin
        errors++; $display("FAIL rnd%0d_timing: lat=%0d acc=%0d want %0d %0d", t, o.lat, o.acc, e.lat, e.acc);
      end
      checks++; if (o.psel_seen !== e.psel || o.psel_end) begin
        errors++; $display("FAIL rnd%0d_psel: seen=%b end=%b want %b 0", t, o.psel_seen, o.psel_end, e.psel);
      end
      if (e.psel) begin
        checks++; if (!o.setup_ok || !o.stable) begin
          errors++; $display("FAIL rnd%0d_apb: setup_ok=%b stable=%b want 1 1", t, o.setup_ok, o.stable);
        end
      end
      checks++; if (o.err !== e.err || o.to !== e.to || o.rdata !== e.rdata) begin
        errors++; $display("FAIL rnd%0d_rsp: err=%b to=%b rdata=%h want %b %b %h", t, o.err, o.to, o.rdata, e.err, e.to, e.rdata);
      end
      checks++; if (!o.hold_ok || !o.release_ok) begin
        errors++; $display("FAIL rnd%0d_handoff: hold=%b release=%b want 1 1", t, o.hold_ok, o.release_ok);
      end
    end
    slave_wait = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_range_err();
    test_timeout();
    test_misaligned();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter AW, default 16, APB address width in bits.
REQ-002 Parameter DW, default 32, APB data width in bits.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS-phase cycles to wait for PREADY; range 1..255.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 PCLK  in  1  clock; all logic on rising edge.
REQ-006 PRESET  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  AW  byte address.
REQ-011 cmd_wdata  in  DW  write data.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-014 rsp_rdata  out  DW  read data; 0 for writes and for errors.
REQ-015 rsp_err  out  1  PSLVERR, timeout or misalignment.
REQ-016 rsp_timeout  out  1  error cause was a timeout.
REQ-017 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-018 PADDR  out  AW;  PWDATA  out  DW  APB address and write data.
REQ-019 PRDATA  in  DW;  PREADY, PSLVERR  in  1 each  APB slave returns.

Function
REQ-020 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-021 cmd_ready SHALL be high only in IDLE.
REQ-022 IDLE + accepted aligned command SHALL capture addr/wdata/write and go to SETUP next cycle.
REQ-023 A command SHALL be aligned when cmd_addr[ADDR_LSB-1:0] == 0, where ADDR_LSB = log2(DW/8).
REQ-024 An accepted misaligned command SHALL issue no APB transfer and go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-025 In SETUP, outputs SHALL be PSEL=1 and PENABLE=0, with PADDR/PWRITE/PWDATA driven from the captured command; the next state is always ACCESS.
REQ-026 In ACCESS, outputs SHALL be PSEL=1 and PENABLE=1, with PADDR/PWRITE/PWDATA held stable.
REQ-027 ACCESS with PREADY=1 SHALL capture PSLVERR into rsp_err and capture PRDATA into rsp_rdata (reads without error only, else 0), then go to RESP.
REQ-028 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-029 When the wait counter reaches TIMEOUT, the block SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0; any later PREADY is ignored.
REQ-030 Outside SETUP/ACCESS, PSEL and PENABLE SHALL be 0; PADDR/PWDATA/PWRITE hold their last values.
REQ-031 In RESP, rsp_valid SHALL be 1 with rsp_* held stable until rsp_ready=1, then go to IDLE.
REQ-032 Throughput SHALL be at most one transaction per 4 cycles (IDLE, SETUP, ACCESS ≥1 cycle, RESP ≥1 cycle).
REQ-033 Aligned-command latency SHALL be: command handshake at cycle N gives rsp_valid at N+3 with zero-wait PREADY, or N+3+w with w wait cycles.
REQ-034 The block SHALL impose no address-range check; range errors come from PSLVERR only.

Reset
REQ-035 PRESET=1 at a clock edge SHALL force IDLE, with PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter 0, and cmd_ready=0 while PRESET is high.
REQ-036 Reset asserted during SETUP/ACCESS SHALL abort the transfer with no response; PSEL drops at that edge.
REQ-037 The first command SHALL be accepted in the first cycle after PRESET deasserts.

Structure
REQ-038 The state enum (IDLE/SETUP/ACCESS/RESP, 2-bit) and the ADDR_LSB computation SHALL live in shared package apb_pkg, reusable by the APB slave and the bench.
REQ-039 The design SHALL be a single module with no sub-module; the timeout counter is inline, width $clog2(TIMEOUT+1).

Verification
REQ-040 Scenario: write 0x0004 ← 0xDEADBEEF, then read 0x0004 with the RAM slave -> write rsp_err=0; read rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-041 Scenario: read 0x0040 (index 16) against the RAM slave -> PSLVERR=1 seen, so rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-042 Scenario: slave holds PREADY=0, TIMEOUT=16 -> PSEL drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1.
REQ-043 Scenario: command addr 0x0002 -> PSEL never asserts; rsp_valid 1 cycle after the handshake with rsp_err=1.
REQ-044 Scenario: rsp_ready low for 5 cycles with cmd_valid held high -> rsp_* stable, cmd_ready=0 throughout; next command accepted 1 cycle after the handshake.
REQ-045 Scenario: PRESET pulsed during ACCESS -> PSEL=0 at the next edge, no rsp_valid, and a fresh write to 0x0008 completes normally.
